// File: rtl/arp_ctrl_pkg.sv
// Shared types and constants for the ARP sequencer (arp_ctrl and its timer).
package arp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_RSP,
    TX_REQ,
    WAIT_TX,
    WAIT_RSP
  } arp_state_t;

  localparam logic        ARP_OP_REQ = 1'b0;
  localparam logic        ARP_OP_RSP = 1'b1;
  localparam logic [47:0] BCAST_MAC  = 48'hFFFF_FFFF_FFFF;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/arp_ctrl_timer.sv
// Loadable down-counter that saturates at zero; expired pulses on the 1->0 step.
module arp_ctrl_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && count != '0)
      count <= count - W'(1);
  end

  assign expired = en && !load && (count == W'(1));
  assign zero    = (count == '0);

endmodule

// File: rtl/arp_ctrl.sv
// ARP sequencer: answers ARP requests, resolves a target IP with timeout/retry.
// Optional periodic re-resolve of the cached entry with ARP_CTRL_REFRESH_EN.
module arp_ctrl
  import arp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 125_000_000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned REFRESH_CYCLES = 625_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_rx_done,
  input  logic        arp_rx_type,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic        tx_done,
  output logic        arp_tx_en,
  output logic        arp_tx_type,
  output logic [47:0] des_mac,
  output logic [31:0] des_ip,
  input  logic        resolve_req,
  input  logic [31:0] target_ip,
  output logic        resolved,
  output logic [47:0] resolved_mac,
  output logic [31:0] resolved_ip,
  output logic        resolve_fail,
  output logic        busy
);

  localparam int unsigned TMR_W = $clog2(max_u(TIMEOUT_CYCLES, REFRESH_CYCLES) + 1);
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 1);

  arp_state_t state, state_nx;

  logic             rsp_pend;
  logic [47:0]      rsp_mac;
  logic [31:0]      rsp_ip;
  logic             req_pend, active, wait_armed;
  logic [31:0]      tgt_ip;
  logic [RTY_W-1:0] retry_cnt;

  logic rx_req, rx_match, req_take, ref_take;
  logic tmo_load, tmo_expired, tmo_zero, tmo_hit;
  logic do_retry, do_fail;

  assign rx_req   = arp_rx_done && (arp_rx_type == ARP_OP_REQ);
  assign rx_match = arp_rx_done && (arp_rx_type == ARP_OP_RSP) && (src_ip == tgt_ip);
  assign req_take = resolve_req && !active;
  // A timeout that fired during a reply detour leaves the counter at zero.
  assign tmo_hit  = tmo_expired || tmo_zero;

  assign arp_tx_en = (state == TX_RSP) || (state == TX_REQ);
  assign busy      = (state != IDLE);

  arp_ctrl_timer #(.W(TMR_W)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .load     (tmo_load),
    .load_val (TMR_W'(TIMEOUT_CYCLES)),
    .en       (wait_armed),
    .expired  (tmo_expired),
    .zero     (tmo_zero)
  );

`ifdef ARP_CTRL_REFRESH_EN
  logic ref_expired, ref_zero, refresh_due;

  arp_ctrl_timer #(.W(TMR_W)) u_ref (
    .clk      (clk),
    .rst      (rst),
    .load     (rx_match),
    .load_val (TMR_W'(REFRESH_CYCLES)),
    .en       (resolved),
    .expired  (ref_expired),
    .zero     (ref_zero)
  );

  // A reload since expiry (fresh reply) suppresses a stale refresh.
  assign ref_take = refresh_due && ref_zero && resolved && (state == IDLE) &&
                    !active && !resolve_req;

  always_ff @(posedge clk) begin
    if (rst)
      refresh_due <= 1'b0;
    else if (ref_take)
      refresh_due <= 1'b0;
    else if (ref_expired)
      refresh_due <= 1'b1;
  end
`else
  assign ref_take = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tmo_load = 1'b0;
    do_retry = 1'b0;
    do_fail  = 1'b0;
    case (state)
      IDLE: begin
        if (rsp_pend)
          state_nx = TX_RSP;
        else if (req_pend)
          state_nx = TX_REQ;
      end
      TX_RSP, TX_REQ: state_nx = WAIT_TX;
      WAIT_TX: begin
        if (tx_done) begin
          if (arp_tx_type == ARP_OP_REQ && active && !rx_match) begin
            state_nx = WAIT_RSP;
            tmo_load = 1'b1;
          end else if (wait_armed && active && !rx_match) begin
            state_nx = WAIT_RSP;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      WAIT_RSP: begin
        if (rx_match || !active)
          state_nx = IDLE;
        else if (rsp_pend)
          state_nx = TX_RSP;
        else if (tmo_hit) begin
          if (retry_cnt < RTY_LAST) begin
            do_retry = 1'b1;
            state_nx = TX_REQ;
          end else begin
            do_fail  = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pend     <= 1'b0;
      rsp_mac      <= '0;
      rsp_ip       <= '0;
      req_pend     <= 1'b0;
      active       <= 1'b0;
      wait_armed   <= 1'b0;
      tgt_ip       <= '0;
      retry_cnt    <= '0;
      arp_tx_type  <= 1'b0;
      des_mac      <= '0;
      des_ip       <= '0;
      resolved     <= 1'b0;
      resolved_mac <= '0;
      resolved_ip  <= '0;
      resolve_fail <= 1'b0;
    end else begin
      // A request seen while its predecessor is being taken stays pending.
      if (rx_req) begin
        rsp_pend <= 1'b1;
        rsp_mac  <= src_mac;
        rsp_ip   <= src_ip;
      end else if (state_nx == TX_RSP) begin
        rsp_pend <= 1'b0;
      end

      if (state_nx == TX_RSP) begin
        arp_tx_type <= ARP_OP_RSP;
        des_mac     <= rsp_mac;
        des_ip      <= rsp_ip;
      end else if (state_nx == TX_REQ) begin
        arp_tx_type <= ARP_OP_REQ;
        des_mac     <= BCAST_MAC;
        des_ip      <= tgt_ip;
      end

      if (tmo_load)
        wait_armed <= 1'b1;
      else if (state_nx == IDLE || state_nx == TX_REQ)
        wait_armed <= 1'b0;

      resolve_fail <= do_fail;
      if (state == IDLE && state_nx == TX_REQ)
        req_pend <= 1'b0;
      if (do_retry)
        retry_cnt <= retry_cnt + RTY_W'(1);
      if (do_fail) begin
        active <= 1'b0;
`ifdef ARP_CTRL_REFRESH_EN
        resolved <= 1'b0;
`endif
      end

      if (rx_match) begin
        resolved     <= 1'b1;
        resolved_mac <= src_mac;
        resolved_ip  <= src_ip;
        req_pend     <= 1'b0;
        active       <= 1'b0;
      end else if (req_take) begin
        req_pend  <= 1'b1;
        active    <= 1'b1;
        tgt_ip    <= target_ip;
        retry_cnt <= '0;
        if (target_ip != resolved_ip)
          resolved <= 1'b0;
      end else if (ref_take) begin
        req_pend  <= 1'b1;
        active    <= 1'b1;
        tgt_ip    <= resolved_ip;
        retry_cnt <= '0;
      end
    end
  end

endmodule
